// File: rtl/fu_pkg.sv
// Shared definitions for the function-unit scheduler: opcodes, flag bit positions, FSM states.
// The scheduler's optional per-requester op counters are enabled with FU_SCHED_OPCOUNT_EN.
package fu_pkg;

  localparam logic [4:0] FS_TRA   = 5'b00000;
  localparam logic [4:0] FS_INC   = 5'b00001;
  localparam logic [4:0] FS_ADD   = 5'b00010;
  localparam logic [4:0] FS_ADDC  = 5'b00011;
  localparam logic [4:0] FS_ADDNB = 5'b00100;
  localparam logic [4:0] FS_SUB   = 5'b00101;
  localparam logic [4:0] FS_DEC   = 5'b00110;
  localparam logic [4:0] FS_TRA2  = 5'b00111;
  localparam logic [4:0] FS_AND   = 5'b01000;
  localparam logic [4:0] FS_OR    = 5'b01010;
  localparam logic [4:0] FS_XOR   = 5'b01100;
  localparam logic [4:0] FS_NOT   = 5'b01110;
  localparam logic [4:0] FS_TRB   = 5'b10000;
  localparam logic [4:0] FS_SRB   = 5'b10100;
  localparam logic [4:0] FS_SLB   = 5'b11000;

  // Bit positions inside the {V,C,Zr,N,Il,Ir} flag vector
  localparam int FLG_V  = 5;
  localparam int FLG_C  = 4;
  localparam int FLG_ZR = 3;
  localparam int FLG_N  = 2;
  localparam int FLG_IL = 1;
  localparam int FLG_IR = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  // MF=1 only supports transfer/shift of B: S = 0000, 0100, 1000
  function automatic logic op_is_legal(input logic [4:0] op);
    return !op[4] || ((op[1:0] == 2'b00) && (op[3:2] != 2'b11));
  endfunction

endpackage

// File: rtl/fu_rr_arbiter.sv
// Two-way round-robin grant: on a contest the requester that did not win last time is chosen.
// Latency: purely combinational. Backpressure: none; the caller qualifies grants with its own state.
module fu_rr_arbiter (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1,
  output logic grant_id
);

  assign grant0   = valid0 && (!valid1 || last_grant);
  assign grant1   = valid1 && (!valid0 || !last_grant);
  assign grant_id = grant1;

endmodule

// File: rtl/fu_scheduler.sv
// Shares one function unit between two requesters (round robin); FU_SCHED_OPCOUNT_EN adds op counters.
// Latency: accept to rsp_valid is FU_LATENCY+1 cycles for legal ops, 1 cycle for illegal ops.
// Backpressure: one op in flight; no request is accepted until the response has been taken.
module fu_scheduler
  import fu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FU_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [5:0]        rsp_flags,
  output logic              rsp_err,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [3:0]        fu_s,
  output logic              fu_mf,
  input  logic [DATA_W-1:0] fu_data,
  input  logic [5:0]        fu_flags,
  output logic [5:0]        status_flags,
  output logic              busy
`ifdef FU_SCHED_OPCOUNT_EN
  ,
  output logic [15:0]       op_count0,
  output logic [15:0]       op_count1
`endif
);

  sched_state_t      state, state_nxt;
  logic [1:0]        wait_cnt;
  logic              last_grant;
  logic              cur_id;
  logic              grant0, grant1, grant_id;
  logic              accept;
  logic [4:0]        acc_op;
  logic [DATA_W-1:0] acc_a, acc_b;

  fu_rr_arbiter u_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last_grant(last_grant),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant_id  (grant_id)
  );

  always_comb begin
    acc_op     = grant_id ? req1_op : req0_op;
    acc_a      = grant_id ? req1_a  : req0_a;
    acc_b      = grant_id ? req1_b  : req0_b;
    accept     = (state == ST_IDLE) && (grant0 || grant1);
    // readies are forced low while reset is asserted so every output reads 0
    req0_ready = reset_n && (state == ST_IDLE) && grant0;
    req1_ready = reset_n && (state == ST_IDLE) && grant1;
    rsp_valid  = (state == ST_RESP);
    busy       = (state != ST_IDLE);
    state_nxt  = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = op_is_legal(acc_op) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt == 2'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= 2'd0;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      fu_a         <= '0;
      fu_b         <= '0;
      fu_s         <= 4'd0;
      fu_mf        <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_flags    <= 6'd0;
      rsp_err      <= 1'b0;
      status_flags <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_id <= grant_id;
            if (op_is_legal(acc_op)) begin
              fu_a     <= acc_a;
              fu_b     <= acc_b;
              fu_s     <= acc_op[3:0];
              fu_mf    <= acc_op[4];
              wait_cnt <= 2'(FU_LATENCY);
            end else begin
              // illegal op never reaches the unit; answer immediately with an error
              rsp_id    <= grant_id;
              rsp_data  <= '0;
              rsp_flags <= 6'd0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            rsp_id    <= cur_id;
            rsp_data  <= fu_data;
            rsp_flags <= fu_flags;
            rsp_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            if (!rsp_err) status_flags <= rsp_flags;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FU_SCHED_OPCOUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count0 <= 16'd0;
      op_count1 <= 16'd0;
    end else if (rsp_valid && rsp_ready && !rsp_err) begin
      if (rsp_id) op_count1 <= op_count1 + 16'd1;
      else        op_count0 <= op_count0 + 16'd1;
    end
  end
`endif

endmodule
